control_unit: RTL

- Hardwired Moore-style control sequencer for the Mini-SRC CPU.
- Sits directly upstream of the datapath. Decodes IR[31:27] and steps the T0..T7 micro-sequence.
- Drives every datapath control strobe (register in/out, bus selects, memory Read/Write, ALU opcode, IncPC).
- Consumes the instruction register value and the CON flip-flop result back from the datapath.

---
 rtl/control_unit_if.sv | 33 +++
 rtl/control_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control-strobe bundle between the Mini-SRC control sequencer and its datapath.
interface control_unit_if #(
  parameter int OPW = 5
);
  logic [31:0]    ir;
  logic           con;
  logic           stop;
  logic           run;
  logic           dp_clear;
  logic           PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InportOut, Cout;
  logic           MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, CONin;
  logic           GRA, GRB, GRC, Rin, Rout, BAout;
  logic           IncPC, Read, Write;
  logic [OPW-1:0] opcode;

  modport master (
    input  ir, con, stop,
    output run, dp_clear,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InportOut, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, CONin,
    output GRA, GRB, GRC, Rin, Rout, BAout,
    output IncPC, Read, Write, opcode
  );

  modport slave (
    output ir, con, stop,
    input  run, dp_clear,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InportOut, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, CONin,
    input  GRA, GRB, GRC, Rin, Rout, BAout,
    input  IncPC, Read, Write, opcode
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini-SRC CPU.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RESET | held while clear is low; datapath clear asserted
// S_T0    | fetch: PC to MAR, increment PC
// S_T1    | fetch: memory read into MDR
// S_T2    | fetch: MDR into IR
// S_T3    | first execute step, decoded from the freshly loaded IR
// S_T4..7 | further execute steps, decoded from the opcode latched in T3
// S_HALT  | stopped; only clear leaves this state
module control_unit #(
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input logic            clock,
  input logic            clear,
  control_unit_if.master cu
);

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_AND  = 5'b01010;
  localparam logic [OPW-1:0] OP_OR   = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] op;
  logic           is_ld, is_ldi, is_st, is_alu, is_imm, is_muldiv, is_negnot;
  logic           is_br, is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt;
  logic           mem_addr;
  state_t         end_state;

  // The opcode is taken straight from IR in T3 and held in op_q for the later steps.
  always_comb begin
    op        = (state_q == S_T3) ? cu.ir[31 -: OPW] : op_q;
    op_d      = (state_q == S_T3) ? cu.ir[31 -: OPW] : op_q;
    is_ld     = (op == OP_LD);
    is_ldi    = (op == OP_LDI);
    is_st     = (op == OP_ST);
    is_alu    = (op >= OP_ADD) && (op <= OP_OR);
    is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
    is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    is_negnot = (op == OP_NEG) || (op == OP_NOT);
    is_br     = (op == OP_BR);
    is_jr     = (op == OP_JR);
    is_in     = (op == OP_IN);
    is_out    = (op == OP_OUT);
    is_mfhi   = (op == OP_MFHI);
    is_mflo   = (op == OP_MFLO);
    is_halt   = (op == OP_HALT);
    mem_addr  = is_ld || is_st || is_ldi;
    end_state = cu.stop ? S_HALT : S_T0;
  end

  // Next-state: each instruction class leaves from its own last T-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (is_halt)
          state_d = S_HALT;
        else if (is_ld || is_ldi || is_st || is_alu || is_imm || is_muldiv || is_negnot || is_br)
          state_d = S_T4;
        else
          state_d = end_state;
      end
      S_T4:    state_d = is_negnot ? end_state : S_T5;
      S_T5:    state_d = (is_ld || is_st || is_br) ? S_T6 : end_state;
      S_T6:    state_d = is_br ? end_state : S_T7;
      S_T7:    state_d = end_state;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State and latched opcode; clear forces RESET without waiting for a clock.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Moore strobe decode of the current T-state and instruction class.
  always_comb begin
    cu.run       = (state_q != S_RESET) && (state_q != S_HALT);
    cu.dp_clear  = (state_q == S_RESET);
    cu.PCout     = 1'b0; cu.Zhighout = 1'b0; cu.Zlowout   = 1'b0; cu.MDRout = 1'b0;
    cu.HIout     = 1'b0; cu.LOout    = 1'b0; cu.InportOut = 1'b0; cu.Cout   = 1'b0;
    cu.MARin     = 1'b0; cu.Zin      = 1'b0; cu.PCin      = 1'b0; cu.MDRin  = 1'b0;
    cu.IRin      = 1'b0; cu.Yin      = 1'b0; cu.LOin      = 1'b0; cu.HIin   = 1'b0;
    cu.OutportIn = 1'b0; cu.CONin    = 1'b0;
    cu.GRA       = 1'b0; cu.GRB      = 1'b0; cu.GRC       = 1'b0;
    cu.Rin       = 1'b0; cu.Rout     = 1'b0; cu.BAout     = 1'b0;
    cu.IncPC     = 1'b0; cu.Read     = 1'b0; cu.Write     = 1'b0;
    cu.opcode    = '0;
    unique case (state_q)
      S_T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; end
      S_T1: begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
      S_T2: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm) begin
          cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1;
        end else if (mem_addr) begin
          cu.GRB = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1;
        end else if (is_muldiv) begin
          cu.GRA = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1;
        end else if (is_negnot) begin
          cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.opcode = op;
        end else if (is_br) begin
          cu.GRA = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1;
        end else if (is_jr) begin
          cu.GRA = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1;
        end else if (is_in) begin
          cu.InportOut = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end else if (is_out) begin
          cu.GRA = 1'b1; cu.Rout = 1'b1; cu.OutportIn = 1'b1;
        end else if (is_mfhi) begin
          cu.HIout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end else if (is_mflo) begin
          cu.LOout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          cu.GRC = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.opcode = op;
        end else if (is_imm || mem_addr) begin
          cu.Cout = 1'b1; cu.Zin = 1'b1;
          cu.opcode = (op == OP_ANDI) ? OP_AND : (op == OP_ORI) ? OP_OR : ADD_OP;
        end else if (is_muldiv) begin
          cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.opcode = op;
        end else if (is_negnot) begin
          cu.Zlowout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end else if (is_br) begin
          cu.PCout = 1'b1; cu.Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_imm || is_ldi) begin
          cu.Zlowout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end else if (is_ld || is_st) begin
          cu.Zlowout = 1'b1; cu.MARin = 1'b1;
        end else if (is_muldiv) begin
          cu.LOin = 1'b1; cu.HIin = 1'b1;
        end else if (is_br) begin
          cu.Cout = 1'b1; cu.Zin = 1'b1; cu.opcode = ADD_OP;
        end
      end
      S_T6: begin
        if (is_ld) begin
          cu.Read = 1'b1; cu.MDRin = 1'b1;
        end else if (is_st) begin
          cu.GRA = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1;
        end else if (is_br && cu.con) begin
          cu.Zlowout = 1'b1; cu.PCin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          cu.MDRout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end else if (is_st) begin
          cu.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
